// File: rtl/mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_ctrl                                                   |
// | Description : Memory-access pipeline stage. Turns load/store requests    |
// |               from the ex/mem register into aligned word transactions on |
// |               a req/gnt/rvalid data bus, forms byte enables, replicates  |
// |               store data per lane, extends load data by access type and  |
// |               stalls upstream while a transaction is outstanding. ALU    |
// |               results pass through to writeback with one cycle latency.  |
// |               data_type_i encoding: 0 none, 1 byte, 2 ubyte, 3 half,     |
// |               4 uhalf, 5 word.                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              ex_w_reg_enable_i,
  input  logic              mem_w_reg_enable_i,
  input  logic [4:0]        w_reg_addr_i,
  input  logic [DATA_W-1:0] ex_w_reg_data_i,
  input  logic              r_mem_enable_i,
  input  logic [ADDR_W-1:0] r_mem_addr_i,
  input  logic              w_mem_enable_i,
  input  logic [ADDR_W-1:0] w_mem_addr_i,
  input  logic [DATA_W-1:0] w_mem_data_i,
  input  logic [2:0]        data_type_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              w_reg_enable_o,
  output logic [4:0]        w_reg_addr_o,
  output logic [DATA_W-1:0] w_reg_data_o
);

  localparam logic [2:0] DT_BYTE  = 3'd1;
  localparam logic [2:0] DT_UBYTE = 3'd2;
  localparam logic [2:0] DT_HALF  = 3'd3;
  localparam logic [2:0] DT_UHALF = 3'd4;
  localparam logic [2:0] DT_WORD  = 3'd5;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              w_access;
  logic              w_store;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_off;
  logic [1:0]        w_size;
  logic              w_legal;
  logic              w_accept;
  logic              w_stall;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_lane;
  logic [DATA_W-1:0] w_load;

  // Context of the accepted load, kept for formatting the returned data.
  logic [1:0]        r_off;
  logic [2:0]        r_dtype;
  logic [4:0]        r_rd;
  logic              r_ld_wen;

  // A store wins over the read enable execute also raises for stores.
  assign w_access = valid_i & (w_mem_enable_i | r_mem_enable_i);
  assign w_store  = w_mem_enable_i;
  assign w_addr   = w_store ? w_mem_addr_i : r_mem_addr_i;
  assign w_off    = w_addr[1:0];
  assign w_accept = (r_state == S_IDLE) & w_access & w_legal;

  // Decode access size; untyped accesses are treated as words.
  always_comb begin
    w_size = SZ_W;
    case (data_type_i)
      DT_BYTE, DT_UBYTE: w_size = SZ_B;
      DT_HALF, DT_UHALF: w_size = SZ_H;
      DT_WORD:           w_size = SZ_W;
      default:           w_size = SZ_W;
    endcase
  end

  // Alignment check, byte enables and lane-replicated store data.
  always_comb begin
    w_legal = 1'b1;
    w_be    = 4'b1111;
    w_wdata = w_mem_data_i;
    case (w_size)
      SZ_B: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{w_mem_data_i[7:0]}};
      end
      SZ_H: begin
        w_legal = ~w_off[0];
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{w_mem_data_i[15:0]}};
      end
      default: begin
        w_legal = (w_off == 2'b00);
        w_be    = 4'b1111;
        w_wdata = w_mem_data_i;
      end
    endcase
  end

  // Shift the addressed lane down and extend it by the captured access type.
  assign w_lane = bus_rdata_i >> {r_off, 3'b000};
  always_comb begin
    w_load = w_lane;
    case (r_dtype)
      DT_BYTE:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      DT_UBYTE: w_load = {24'd0, w_lane[7:0]};
      DT_HALF:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      DT_UHALF: w_load = {16'd0, w_lane[15:0]};
      default:  w_load = w_lane;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and stall; stall drops in the load completion cycle.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access & w_legal) begin
          w_next  = S_REQ;
          w_stall = 1'b1;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (bus_gnt_i) w_next = bus_we_o ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (bus_rvalid_i) w_next  = S_IDLE;
        else              w_stall = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign stall_o = w_stall & ~rst;

  // Bus request registers, loaded on acceptance and held until granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= 4'b0000;
      bus_wdata_o <= '0;
      r_off       <= 2'b00;
      r_dtype     <= 3'd0;
      r_rd        <= 5'd0;
      r_ld_wen    <= 1'b0;
    end else if (w_accept) begin
      bus_req_o   <= 1'b1;
      bus_we_o    <= w_store;
      bus_addr_o  <= {w_addr[ADDR_W-1:2], 2'b00};
      bus_be_o    <= w_be;
      bus_wdata_o <= w_wdata;
      r_off       <= w_off;
      r_dtype     <= data_type_i;
      r_rd        <= w_reg_addr_i;
      r_ld_wen    <= mem_w_reg_enable_i;
    end else if ((r_state == S_REQ) && bus_gnt_i) begin
      bus_req_o   <= 1'b0;
    end
  end

  // Writeback and misalign pulse: ALU pass-through, load return, dropped access.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_reg_enable_o <= 1'b0;
      w_reg_addr_o   <= 5'd0;
      w_reg_data_o   <= '0;
      misalign_o     <= 1'b0;
    end else begin
      w_reg_enable_o <= 1'b0;
      misalign_o     <= 1'b0;
      if ((r_state == S_IDLE) && valid_i) begin
        if (!w_access) begin
          w_reg_enable_o <= ex_w_reg_enable_i;
          w_reg_addr_o   <= w_reg_addr_i;
          w_reg_data_o   <= ex_w_reg_data_i;
        end else if (!w_legal) begin
          misalign_o     <= 1'b1;
        end
      end else if ((r_state == S_WAIT) && bus_rvalid_i) begin
        w_reg_enable_o <= r_ld_wen;
        w_reg_addr_o   <= r_rd;
        w_reg_data_o   <= w_load;
      end
    end
  end

endmodule
`default_nettype wire
